l1d_tx_dat_adapter: RTL and testbench

L1D_TX_DAT_ADAPTER -- requirements
Module: l1d_tx_dat_adapter

---
 rtl/l1d_tx_dat_adapter.sv | 152 +++++++++++++++
 tb/tb_l1d_tx_dat_adapter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/l1d_tx_dat_adapter.sv
// l1d_tx_dat_adapter
// Buffers evict data beats from the data RAM pipe in a small credit FIFO and
// forwards them as TX DAT flits, gated by link-layer credits.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   evict_en/id/dat      - one-cycle evict write pulse with TxnID and payload
//   adp_crdv             - one-cycle buffer-credit return per popped entry
//   tx_dat_flitpend      - early indication, high the cycle before flitv
//   tx_dat_flitv/flit    - registered flit valid and payload
//   tx_dat_lcrdv         - one-cycle link-layer credit grant
//   err_ovf              - sticky overflow (FIFO drop or credit overflow)
//
// Optional feature macro: L1D_TX_DAT_PARITY_EN
//   defined   -> flit = {par, id, dat}, par = even parity over {id, dat}
//   undefined -> flit = {id, dat}

`ifndef L1D_MSHR_ID_WIDTH
`define L1D_MSHR_ID_WIDTH 8
`endif
`ifndef REQ_DATA_WIDTH
`define REQ_DATA_WIDTH 64
`endif

module l1d_tx_dat_adapter #(
   parameter int FIFO_DEPTH = 4,
   parameter int LCRD_MAX   = 15,
   parameter int ID_W       = `L1D_MSHR_ID_WIDTH,
   parameter int DAT_W      = `REQ_DATA_WIDTH,
`ifdef L1D_TX_DAT_PARITY_EN
   localparam int FLIT_W    = ID_W + DAT_W + 1
`else
   localparam int FLIT_W    = ID_W + DAT_W
`endif
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evict_en,
   input  logic [ID_W-1:0]   evict_id,
   input  logic [DAT_W-1:0]  evict_dat,
   output logic              adp_crdv,
   output logic              tx_dat_flitpend,
   output logic              tx_dat_flitv,
   output logic [FLIT_W-1:0] tx_dat_flit,
   input  logic              tx_dat_lcrdv,
   output logic              err_ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(LCRD_MAX + 1);
   localparam int EW = ID_W + DAT_W;

`ifdef L1D_TX_DAT_PARITY_EN
   function automatic logic even_par_f(input logic [EW-1:0] v);
      return ^v;
   endfunction
`endif

   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [PW:0]       wptr_q, wptr_d;
   logic [PW:0]       rptr_q, rptr_d;
   logic [CW-1:0]     crd_cnt_q, crd_cnt_d;
   logic              err_ovf_q, err_ovf_d;
   logic              flitv_q;
   logic              crdv_q;
   logic [FLIT_W-1:0] flit_q, flit_d;

   logic              empty_s, full_s, send_s, push_s, drop_s, crd_ovf_s;
   logic [EW-1:0]     head_s;

   // Extra wrap bit distinguishes full (wrap differs) from empty (all equal).
   assign empty_s = (wptr_q == rptr_q);
   assign full_s  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign send_s  = !empty_s && (crd_cnt_q != {CW{1'b0}});
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_s  = evict_en && (!full_s || send_s);
   assign drop_s  = evict_en && full_s && !send_s;
   assign head_s  = mem_q[rptr_q[PW-1:0]];

   // Pointer, credit, error and flit next-state
   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      crd_cnt_d = crd_cnt_q;
      crd_ovf_s = 1'b0;
      flit_d    = flit_q;
      if (push_s) begin
         wptr_d = wptr_q + {{PW{1'b0}}, 1'b1};
      end else begin
         wptr_d = wptr_q;
      end
      if (send_s) begin
         rptr_d = rptr_q + {{PW{1'b0}}, 1'b1};
`ifdef L1D_TX_DAT_PARITY_EN
         flit_d = {even_par_f(head_s), head_s};
`else
         flit_d = head_s;
`endif
      end else begin
         rptr_d = rptr_q;
         flit_d = flit_q;
      end
      // A grant arriving together with a send nets to no change, even at max.
      case ({tx_dat_lcrdv, send_s})
         2'b10: begin
            if (crd_cnt_q == CW'(LCRD_MAX)) begin
               crd_ovf_s = 1'b1;
            end else begin
               crd_cnt_d = crd_cnt_q + CW'(1);
            end
         end
         2'b01:   crd_cnt_d = crd_cnt_q - CW'(1);
         default: crd_cnt_d = crd_cnt_q;
      endcase
      err_ovf_d = err_ovf_q | drop_s | crd_ovf_s;
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         crd_cnt_q <= '0;
         err_ovf_q <= 1'b0;
         flitv_q   <= 1'b0;
         crdv_q    <= 1'b0;
         flit_q    <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         crd_cnt_q <= crd_cnt_d;
         err_ovf_q <= err_ovf_d;
         flitv_q   <= send_s;
         crdv_q    <= send_s;
         flit_q    <= flit_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wptr_q[PW-1:0]] <= {evict_id, evict_dat};
      end
   end

   assign tx_dat_flitpend = send_s;
   assign tx_dat_flitv    = flitv_q;
   assign tx_dat_flit     = flit_q;
   assign adp_crdv        = crdv_q;
   assign err_ovf         = err_ovf_q;

endmodule

// File: tb/tb_l1d_tx_dat_adapter.sv
module tb_l1d_tx_dat_adapter;

   localparam int DEPTH = 4;
   localparam int LMAX  = 15;
   localparam int ID_W  = 6;
   localparam int DAT_W = 16;
   localparam int EW    = ID_W + DAT_W;
`ifdef L1D_TX_DAT_PARITY_EN
   localparam int FLIT_W = EW + 1;
`else
   localparam int FLIT_W = EW;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              evict_en = 1'b0;
   logic [ID_W-1:0]   evict_id = '0;
   logic [DAT_W-1:0]  evict_dat = '0;
   logic              adp_crdv;
   logic              tx_dat_flitpend;
   logic              tx_dat_flitv;
   logic [FLIT_W-1:0] tx_dat_flit;
   logic              tx_dat_lcrdv = 1'b0;
   logic              err_ovf;

   l1d_tx_dat_adapter #(.FIFO_DEPTH(DEPTH), .LCRD_MAX(LMAX), .ID_W(ID_W), .DAT_W(DAT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .evict_en(evict_en), .evict_id(evict_id), .evict_dat(evict_dat),
      .adp_crdv(adp_crdv), .tx_dat_flitpend(tx_dat_flitpend),
      .tx_dat_flitv(tx_dat_flitv), .tx_dat_flit(tx_dat_flit),
      .tx_dat_lcrdv(tx_dat_lcrdv), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: a queue of entries, a credit count, a sticky error
   logic [EW-1:0]     mq[$];
   int                m_cred;
   bit                m_err;
   bit                m_flitv;
   bit                m_crdv;
   logic [FLIT_W-1:0] m_flit;
   int                seen_flitv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [EW-1:0] e);
`ifdef L1D_TX_DAT_PARITY_EN
      return {^e, e};
`else
      return e;
`endif
   endfunction

   function automatic bit m_send();
      return (mq.size() > 0) && (m_cred > 0);
   endfunction

   // One cycle: compare outputs at the falling edge, drive inputs, advance model
   task automatic step(input bit en, input logic [ID_W-1:0] id, input logic [DAT_W-1:0] dat, input bit lc);
      bit snd;
      @(negedge clk);
      snd = m_send();
      chk("flitpend", 64'(tx_dat_flitpend), 64'(snd));
      chk("flitv",    64'(tx_dat_flitv),    64'(m_flitv));
      chk("flit",     64'(tx_dat_flit),     64'(m_flit));
      chk("adp_crdv", 64'(adp_crdv),        64'(m_crdv));
      chk("err_ovf",  64'(err_ovf),         64'(m_err));
      if (tx_dat_flitv) seen_flitv++;
      evict_en = en; evict_id = id; evict_dat = dat; tx_dat_lcrdv = lc;
      if (snd) begin
         m_flit = mk_flit(mq.pop_front());
         m_cred--;
      end
      m_flitv = snd;
      m_crdv  = snd;
      if (lc) begin
         if (snd || m_cred < LMAX) m_cred++;
         else m_err = 1'b1;
      end
      if (en) begin
         if (mq.size() < DEPTH) mq.push_back({id, dat});
         else m_err = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
   endtask

   // Asynchronous reset mid-cycle; release mid-high so the next edge is usable
   task automatic do_reset();
      @(negedge clk);
      evict_en = 1'b0; tx_dat_lcrdv = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_flitpend", 64'(tx_dat_flitpend), 64'd0);
      chk("rst_flitv",    64'(tx_dat_flitv),    64'd0);
      chk("rst_crdv",     64'(adp_crdv),        64'd0);
      chk("rst_err",      64'(err_ovf),         64'd0);
      chk("rst_flit",     64'(tx_dat_flit),     64'd0);
      mq.delete(); m_cred = 0; m_err = 1'b0;
      m_flitv = 1'b0; m_crdv = 1'b0; m_flit = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int en_pct, lc_pct;
      do_reset();

      // Single transaction latency and flit content
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
      step(1'b1, 6'd5, 16'h00A5, 1'b0);
      @(posedge clk); #1;
      chk("k1_flitpend", 64'(tx_dat_flitpend), 64'd1);
      chk("k1_flitv",    64'(tx_dat_flitv),    64'd0);
      step(1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      chk("k2_flitv", 64'(tx_dat_flitv), 64'd1);
      chk("k2_flit",  64'(tx_dat_flit),  64'(mk_flit({6'd5, 16'h00A5})));
      chk("k2_crdv",  64'(adp_crdv),     64'd1);
      chk("k2_cred",  64'(m_cred),       64'd2);
      idle(3);

      // Fill with no credits, overflow on the fifth, then drain in order
      do_reset();
      for (int i = 1; i <= 5; i++) step(1'b1, 6'(i), 16'(16'h1100 + i), 1'b0);
      @(posedge clk); #1;
      chk("ovf_drop_err", 64'(err_ovf), 64'd1);
      chk("ovf_held",     64'(mq.size()), 64'd4);
      seen_flitv = 0;
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
      idle(4);
      chk("drain_count", 64'(seen_flitv), 64'd4);
      chk("ovf_sticky",  64'(err_ovf),   64'd1);

      // Full FIFO with one credit: simultaneous send and push, no drop
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 6'(i + 8), 16'(16'h2200 + i), 1'b0);
      step(1'b0, '0, '0, 1'b1);
      step(1'b1, 6'd9, 16'h2299, 1'b0);
      @(posedge clk); #1;
      chk("full_push_err", 64'(err_ovf), 64'd0);
      chk("full_occ",      64'(mq.size()), 64'd4);
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1);
      idle(5);

      // Credit counter saturation
      do_reset();
      for (int i = 0; i < LMAX; i++) step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      @(posedge clk); #1;
      chk("crd_ovf_err", 64'(err_ovf), 64'd1);
      chk("crd_ovf_cnt", 64'(m_cred),  64'd15);
      do_reset();
      for (int i = 0; i < LMAX; i++) step(1'b0, '0, '0, 1'b1);
      step(1'b1, 6'd1, 16'h0000, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      @(posedge clk); #1;
      chk("crd_max_send_err", 64'(err_ovf), 64'd0);
      chk("crd_max_send_cnt", 64'(m_cred),  64'd15);
`ifdef L1D_TX_DAT_PARITY_EN
      chk("par_id1", 64'(tx_dat_flit[FLIT_W-1]), 64'd1);
      step(1'b1, 6'd3, 16'h0000, 1'b0);
      idle(1);
      @(posedge clk); #1;
      chk("par_id3", 64'(tx_dat_flit[FLIT_W-1]), 64'd0);
`endif
      idle(3);

      // Reset mid-stream, then no traffic without new credits and data
      do_reset();
      step(1'b1, 6'd2, 16'h3301, 1'b0);
      step(1'b1, 6'd3, 16'h3302, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
      do_reset();
      seen_flitv = 0;
      idle(6);
      chk("post_rst_noflit", 64'(seen_flitv), 64'd0);

      // Randomized traffic with varying push/credit pressure
      for (int blk = 0; blk < 8; blk++) begin
         en_pct = int'($urandom_range(10, 95));
         lc_pct = int'($urandom_range(10, 95));
         if (blk % 3 == 0) do_reset();
         for (int i = 0; i < 250; i++) begin
            step(($urandom_range(0, 99) < en_pct), 6'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < lc_pct));
         end
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
